pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: sequential, branch, jump, register and trap targets.
// Define PC_GEN_RAS_EN to add the circular return-address stack used by call/return.
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 'h80,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             trap,
  input  logic [2:0]       pc_sel,
  input  logic [WIDTH-1:0] reg_target,
  input  logic [WIDTH-1:0] imm,
  input  logic [25:0]      jaddr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf
);

  localparam logic [2:0] SEL_REG  = 3'b001;
  localparam logic [2:0] SEL_BR   = 3'b010;
  localparam logic [2:0] SEL_JMP  = 3'b011;
  localparam logic [2:0] SEL_CALL = 3'b100;
  localparam logic [2:0] SEL_RET  = 3'b101;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] reg_aligned, jump_tgt, branch_tgt, ret_tgt;
  logic             update;

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + WIDTH'(4);
  assign update      = ~stall | trap;
  // Masking instead of slicing keeps every reg_target bit in use.
  assign reg_aligned = reg_target & ~{{(WIDTH-2){1'b0}}, 2'b11};
  assign jump_tgt    = {pc_plus4[WIDTH-1:28], jaddr, 2'b00};
  assign branch_tgt  = pc_plus4 + (imm << 2);

`ifdef PC_GEN_RAS_EN
  localparam int             PW       = $clog2(RAS_DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, top_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, push, pop;

  assign top_ptr   = wr_ptr_q - PW'(1);
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == FULL_CNT);
  assign ras_ovf   = ovf_q;
  assign ret_tgt   = ras_empty ? reg_aligned : ras_mem_q[top_ptr];

  // A push while full lands on the oldest slot, since the write pointer wraps onto it.
  always_comb begin
    push     = update & ~trap & (pc_sel == SEL_CALL);
    pop      = update & ~trap & (pc_sel == SEL_RET) & ~ras_empty;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (ras_full) ovf_d = 1'b1;
      else          count_d = count_q + CW'(1);
    end else if (pop) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) ras_mem_q[wr_ptr_q] <= pc_plus4;
  end
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ret_tgt   = reg_aligned;
`endif

  always_comb begin
    pc_d = pc_plus4;
    case (pc_sel)
      SEL_REG:           pc_d = reg_aligned;
      SEL_BR:            pc_d = branch_tgt;
      SEL_JMP, SEL_CALL: pc_d = jump_tgt;
      SEL_RET:           pc_d = ret_tgt;
      default:           pc_d = pc_plus4;
    endcase
    if (trap)         pc_d = TRAP_VEC;
    else if (!update) pc_d = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VEC;
    else     pc_q <= pc_d;
  end

endmodule
